ram_wr_arb: RTL and testbench

RAM_WR_ARB -- requirements
Module: ram_wr_arb

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 14 +
 rtl/ram_wr_arb.sv | 123 ++++++++++++
 tb/tb_ram_wr_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM write-port arbiter: state encoding, burst-length
// default and counter sizing.
package ram_ctrl_pkg;

  localparam int unsigned MAXB_DEFAULT = 16;

  // Encoding is chosen so each state's value is the one-hot grant it drives.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  function automatic int unsigned cnt_width(input int unsigned maxb);
    return (maxb <= 2) ? 1 : $clog2(maxb);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: with both requesters valid, the one that did not
// own the port last (rr_ptr) wins; otherwise the single valid requester wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic       pick
);

  always_comb begin
    pick = valid[1];
    if (valid == 2'b11) pick = ~rr_ptr;
  end

endmodule

// File: rtl/ram_wr_arb.sv
// Arbitrates two bursting write requesters onto a single registered RAM write port,
// with round-robin tie-break and a forced release after MAXB beats.
module ram_wr_arb
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DWI  = 8,
  parameter int unsigned AWI  = 7,
  parameter int unsigned MAXB = MAXB_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s0_valid,
  output logic           s0_ready,
  input  logic [AWI-1:0] s0_addr,
  input  logic [DWI-1:0] s0_data,
  input  logic           s0_last,
  input  logic           s1_valid,
  output logic           s1_ready,
  input  logic [AWI-1:0] s1_addr,
  input  logic [DWI-1:0] s1_data,
  input  logic           s1_last,
  output logic           wr_en,
  output logic [AWI-1:0] wr_addr,
  output logic [DWI-1:0] wr_data,
  output logic [1:0]     grant
);

  localparam int unsigned    CW       = cnt_width(MAXB);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAXB - 1);

  arb_state_t     state, state_nx;
  logic           rr_ptr, rr_ptr_nx;
  logic [CW-1:0]  beat_cnt, beat_cnt_nx;
  logic           pick;
  logic           beat, cur_last, other_valid, rel;
  logic [AWI-1:0] cur_addr;
  logic [DWI-1:0] cur_data;

  assign grant    = {state == GNT1, state == GNT0};
  assign s0_ready = grant[0];
  assign s1_ready = grant[1];

  rr_arb2 u_pick (
    .valid  ({s1_valid, s0_valid}),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  always_comb begin
    beat        = 1'b0;
    cur_last    = 1'b0;
    other_valid = 1'b0;
    cur_addr    = s0_addr;
    cur_data    = s0_data;
    case (state)
      GNT0: begin
        beat        = s0_valid;
        cur_last    = s0_last;
        other_valid = s1_valid;
      end
      GNT1: begin
        beat        = s1_valid;
        cur_last    = s1_last;
        other_valid = s0_valid;
        cur_addr    = s1_addr;
        cur_data    = s1_data;
      end
      default: ;
    endcase
    // last and the count limit fold into one release, so a coinciding pair releases once.
    rel = beat && (cur_last || (beat_cnt == CNT_LAST));
  end

  always_comb begin
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    case (state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          state_nx    = pick ? GNT1 : GNT0;
          rr_ptr_nx   = pick;
          beat_cnt_nx = '0;
        end
      end
      GNT0, GNT1: begin
        if (rel) begin
          if (other_valid) begin
            state_nx    = (state == GNT0) ? GNT1 : GNT0;
            rr_ptr_nx   = (state == GNT0);
            beat_cnt_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else if (beat) begin
          beat_cnt_nx = beat_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b1;
      beat_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      wr_en    <= beat;
      if (beat) begin
        wr_addr <= cur_addr;
        wr_data <= cur_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_arb.sv
// Directed bench for ram_wr_arb: expected RAM writes are queued as beats are issued
// and a negedge monitor compares every wr_en strobe against the queue in order.
module tb_ram_wr_arb;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_ready, s1_ready;
  logic [6:0] s0_addr = '0, s1_addr = '0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] grant;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  ram_wr_arb #(.DWI(8), .AWI(7), .MAXB(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s0_last  (s0_last),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .s1_last  (s1_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .grant    (grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [6:0] a, input logic [7:0] d, input logic l);
    s0_valid = v; s0_addr = a; s0_data = d; s0_last = l;
  endtask

  task automatic set1(input logic v, input logic [6:0] a, input logic [7:0] d, input logic l);
    s1_valid = v; s1_addr = a; s1_data = d; s1_last = l;
  endtask

  task automatic push(input logic [6:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("sb_drained_at_reset", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h, none expected at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h at %0t",
                   wr_addr, wr_data, e.addr, e.data, $time);
        end
      end
    end else if (wr_en !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_wr_en_unknown: got %b expected 0/1 at %0t", wr_en, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single beat after reset
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    set0(1, 7'd5, 8'hA5, 1);
    push(7'd5, 8'hA5);
    tick();
    chk("single_grant_c1", grant, 2'b01);
    chk("single_s0_ready", s0_ready, 1);
    chk("single_wr_en_c1", wr_en, 0);
    tick();
    set0(0, '0, '0, 0);
    chk("single_wr_en_c2", wr_en, 1);
    chk("single_wr_addr", wr_addr, 7'd5);
    chk("single_wr_data", wr_data, 8'hA5);
    chk("single_idle", grant, 2'b00);
    tick();
    chk("single_wr_en_c3", wr_en, 0);
    chk("single_addr_hold", wr_addr, 7'd5);

    // Tie, handover, round-robin
    do_reset();
    set0(1, 7'h10, 8'h11, 0);
    set1(1, 7'h20, 8'h21, 0);
    tick();
    chk("tie1_grant", grant, 2'b01);
    chk("tie1_s1_ready", s1_ready, 0);
    push(7'h10, 8'h11);
    tick();
    set0(1, 7'h12, 8'h13, 1);
    push(7'h12, 8'h13);
    tick();
    chk("handover_grant", grant, 2'b10);
    set0(0, '0, '0, 0);
    push(7'h20, 8'h21);
    tick();
    set1(1, 7'h22, 8'h23, 1);
    push(7'h22, 8'h23);
    tick();
    chk("tie_idle", grant, 2'b00);
    set0(1, 7'h30, 8'h31, 1);
    set1(1, 7'h40, 8'h41, 1);
    tick();
    chk("tie2_grant", grant, 2'b01);
    push(7'h30, 8'h31);
    tick();
    set0(0, '0, '0, 0);
    chk("tie2_handover", grant, 2'b10);
    push(7'h40, 8'h41);
    tick();
    set1(0, '0, '0, 0);
    chk("tie2_idle", grant, 2'b00);
    tick();

    // Forced release after 16 beats, s0 pending
    do_reset();
    set1(1, 7'd0, 8'h80, 0);
    tick();
    chk("force_grant", grant, 2'b10);
    for (int i = 0; i < 20; i++) begin
      set1(1, 7'(i), 8'(8'h80 + i), 0);
      push(7'(i), 8'(8'h80 + i));
      if (i == 3) set0(1, 7'h7F, 8'hEE, 1);
      tick();
      if (i == 14) chk("force_not_early", grant, 2'b10);
      if (i == 15) begin
        chk("force_release_gnt0", grant, 2'b01);
        push(7'h7F, 8'hEE);
        tick();
        set0(0, '0, '0, 0);
        chk("force_back_gnt1", grant, 2'b10);
      end
    end
    chk("force_second_grant_held", grant, 2'b10);
    set1(0, '0, '0, 0);
    tick();
    chk("owner_idle_keeps_grant", grant, 2'b10);

    // Owner stalls mid-burst
    do_reset();
    set0(1, 7'h40, 8'h50, 0);
    tick();
    chk("stall_grant", grant, 2'b01);
    push(7'h40, 8'h50);
    tick();
    set0(0, 7'h40, 8'h50, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_grant_held", grant, 2'b01);
      chk("stall_wr_en", wr_en, 0);
    end
    for (int i = 1; i < 16; i++) begin
      set0(1, 7'(8'h40 + i), 8'(8'h50 + i), 0);
      push(7'(8'h40 + i), 8'(8'h50 + i));
      tick();
      if (i == 14) chk("stall_cnt_unchanged", grant, 2'b01);
    end
    set0(0, '0, '0, 0);
    chk("stall_forced_release", grant, 2'b00);
    tick();

    // Reset mid-burst
    do_reset();
    set0(1, 7'h60, 8'h90, 0);
    tick();
    push(7'h60, 8'h90);
    tick();
    set0(1, 7'h61, 8'h91, 0);
    push(7'h61, 8'h91);
    tick();
    set0(1, 7'h62, 8'h92, 0);
    rst = 1'b1;
    tick();
    chk("abort_wr_en", wr_en, 0);
    chk("abort_grant", grant, 2'b00);
    chk("abort_s0_ready", s0_ready, 0);
    rst = 1'b0;
    set0(1, 7'h70, 8'hA0, 1);
    set1(1, 7'h71, 8'hB0, 1);
    tick();
    chk("abort_tie_s0_wins", grant, 2'b01);
    push(7'h70, 8'hA0);
    tick();
    set0(0, '0, '0, 0);
    push(7'h71, 8'hB0);
    tick();
    set1(0, '0, '0, 0);
    chk("abort_final_idle", grant, 2'b00);
    tick();
    tick();
    chk("sb_drained_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
